sdram_pattern_checker: RTL and testbench



---
 rtl/sdram_tester_pkg.sv | 15 +
 rtl/sdram_pattern_checker_if.sv | 29 ++
 rtl/sdram_pattern_gen.sv | 26 ++
 rtl/sdram_pattern_checker.sv | 168 ++++++++++++++++
 tb/tb_sdram_pattern_checker.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_tester_pkg.sv
// Shared types and constants for the sdram_tester pattern checker/writer blocks.
package sdram_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CMP,
        FIN
    } checker_state_t;

    localparam logic [31:0] LANE_STEP    = 32'h0101_0101;
    localparam logic [31:0] DEFAULT_SEED = 32'hA5A5_0000;

endpackage

// File: rtl/sdram_pattern_checker_if.sv
// Read-request channel between the pattern checker (master) and the SDRAM read bridge (slave).
interface sdram_pattern_checker_if #(
    parameter int WIDTH_BITS = 128,
    parameter int ADDR_BITS  = 26
) ();

    logic                  rd_req;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic                  rd_ack;
    logic                  rd_valid;
    logic [WIDTH_BITS-1:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/sdram_pattern_gen.sv
// Combinational address -> expected data word; each 32-bit lane is SEED ^ addr ^ lane*LANE_STEP.
module sdram_pattern_gen
    import sdram_tester_pkg::*;
#(
    parameter int          WIDTH_BITS = 128,
    parameter int          ADDR_BITS  = 26,
    parameter logic [31:0] SEED       = DEFAULT_SEED
) (
    input  logic [ADDR_BITS-1:0]  addr,
    output logic [WIDTH_BITS-1:0] pattern
);

    localparam int LANES = WIDTH_BITS / 32;

    logic [31:0] addr_ext;

    assign addr_ext = 32'(addr);

    always_comb begin
        pattern = '0;
        for (int i = 0; i < LANES; i++) begin
            pattern[i*32 +: 32] = SEED ^ addr_ext ^ (LANE_STEP * 32'(i));
        end
    end

endmodule

// File: rtl/sdram_pattern_checker.sv
// Walks an address range through the read bridge, one read outstanding, and checks each word
// against the address-derived pattern; results hold until the next start or reset.
module sdram_pattern_checker
    import sdram_tester_pkg::*;
#(
    parameter int          INTERFACE_WIDTH_BITS = 128,
    parameter int          INTERFACE_ADDR_BITS  = 26,
    parameter int          ADDR_STEP            = 16,
    parameter int          COUNT_BITS           = 16,
    parameter int          TIMEOUT_CYCLES       = 1024,
    parameter logic [31:0] SEED                 = DEFAULT_SEED
) (
    input  logic                            interface_clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [INTERFACE_ADDR_BITS-1:0]  start_addr,
    input  logic [COUNT_BITS-1:0]           num_words,
    sdram_pattern_checker_if.master         rd_bus,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            timeout,
    output logic [COUNT_BITS-1:0]           error_count,
    output logic [INTERFACE_ADDR_BITS-1:0]  first_err_addr,
    output logic [INTERFACE_WIDTH_BITS-1:0] first_err_data
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    checker_state_t                  state_q, state_d;
    logic [INTERFACE_ADDR_BITS-1:0]  addr_q, addr_d;
    logic [COUNT_BITS-1:0]           remaining_q, remaining_d;
    logic [TMR_W-1:0]                timer_q, timer_d;
    logic [INTERFACE_WIDTH_BITS-1:0] data_q, data_d;
    logic [COUNT_BITS-1:0]           error_count_q, error_count_d;
    logic [INTERFACE_ADDR_BITS-1:0]  first_err_addr_q, first_err_addr_d;
    logic [INTERFACE_WIDTH_BITS-1:0] first_err_data_q, first_err_data_d;
    logic                            pass_q, pass_d;
    logic                            timeout_q, timeout_d;
    logic                            rd_req;
    logic [INTERFACE_WIDTH_BITS-1:0] expected;

    sdram_pattern_gen #(
        .WIDTH_BITS (INTERFACE_WIDTH_BITS),
        .ADDR_BITS  (INTERFACE_ADDR_BITS),
        .SEED       (SEED)
    ) u_pattern_gen (
        .addr    (addr_q),
        .pattern (expected)
    );

    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        timer_d          = '0;
        data_d           = data_q;
        error_count_d    = error_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        rd_req           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d           = start_addr;
                    remaining_d      = num_words;
                    error_count_d    = '0;
                    first_err_addr_d = '0;
                    first_err_data_d = '0;
                    pass_d           = 1'b0;
                    timeout_d        = 1'b0;
                    state_d          = (num_words == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                rd_req = 1'b1;
                if (rd_bus.rd_ack) begin
                    if (rd_bus.rd_valid) begin
                        data_d  = rd_bus.rd_data;
                        state_d = CMP;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT: begin
                // Data arriving on the last allowed cycle still counts as a response.
                if (rd_bus.rd_valid) begin
                    data_d  = rd_bus.rd_data;
                    state_d = CMP;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CMP: begin
                if (data_q != expected) begin
                    if (error_count_q != '1) begin
                        error_count_d = error_count_q + 1'b1;
                    end
                    if (error_count_q == '0) begin
                        first_err_addr_d = addr_q;
                        first_err_data_d = data_q;
                    end
                end
                addr_d      = addr_q + INTERFACE_ADDR_BITS'(ADDR_STEP);
                remaining_d = remaining_q - 1'b1;
                state_d     = (remaining_q == COUNT_BITS'(1)) ? FIN : REQ;
            end
            FIN: begin
                pass_d  = (error_count_q == '0) && !timeout_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge interface_clock) begin
        if (reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            remaining_q      <= '0;
            timer_q          <= '0;
            data_q           <= '0;
            error_count_q    <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q          <= state_d;
            addr_q           <= addr_d;
            remaining_q      <= remaining_d;
            timer_q          <= timer_d;
            data_q           <= data_d;
            error_count_q    <= error_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
        end
    end

    assign rd_bus.rd_req   = rd_req;
    assign rd_bus.rd_addr  = addr_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FIN);
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign error_count     = error_count_q;
    assign first_err_addr  = first_err_addr_q;
    assign first_err_data  = first_err_data_q;

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Self-checking bench: table-driven runs, randomized runs against a run-level reference model,
// and hand-written sequences for idle rd_valid and reset in the middle of a run.
module tb_sdram_pattern_checker;

    localparam int T = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [25:0]   start_addr;
    logic [15:0]   num_words;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [15:0]   error_count;
    logic [25:0]   first_err_addr;
    logic [127:0]  first_err_data;

    int checks = 0;
    int errors = 0;

    sdram_pattern_checker_if #(.WIDTH_BITS(128), .ADDR_BITS(26)) bus ();

    sdram_pattern_checker #(
        .INTERFACE_WIDTH_BITS (128),
        .INTERFACE_ADDR_BITS  (26),
        .ADDR_STEP            (16),
        .COUNT_BITS           (16),
        .TIMEOUT_CYCLES       (T),
        .SEED                 (32'hA5A5_0000)
    ) dut (
        .interface_clock (clk),
        .reset           (reset),
        .start           (start),
        .start_addr      (start_addr),
        .num_words       (num_words),
        .rd_bus          (bus),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .error_count     (error_count),
        .first_err_addr  (first_err_addr),
        .first_err_data  (first_err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [25:0] sa;
        int          n;
        int          ack_dly;
        int          lat;
        logic [7:0]  mask;
        bit          restart;
        int          exp_err;
        bit          exp_pass;
        bit          exp_to;
        logic [25:0] exp_first;
    } vec_t;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Lane i of the expected word is the seed, xor the address, xor byte i replicated four times.
    function automatic logic [127:0] exp_word(input logic [25:0] a);
        logic [127:0] w;
        logic [7:0]   b;
        for (int i = 0; i < 4; i++) begin
            b = 8'(i);
            w[i*32 +: 32] = 32'hA5A5_0000 ^ {6'b0, a} ^ {4{b}};
        end
        return w;
    endfunction

    function automatic logic [25:0] word_addr(input logic [25:0] sa, input int k);
        return 26'(sa + 26'(16 * k));
    endfunction

    task automatic run_vec(input string tag, input logic [25:0] sa, input int n, input int ack_dly,
                           input int lat, input logic [7:0] mask, input logic [127:0] flip,
                           input bit restart, input int exp_err, input bit exp_pass,
                           input bit exp_to, input logic [25:0] exp_first);
        int cyc, req_idx, req_cycles, cd, pend_k, req_hi, dones, done_cyc, exp_cyc, exp_hi;
        bit finished, to_in_req;
        logic [127:0] exp_data;
        cyc = 0; req_idx = 0; req_cycles = 0; cd = 0; pend_k = 0; req_hi = 0;
        dones = 0; done_cyc = -1; finished = 0;

        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        num_words  = 16'(n);
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (restart && cyc == 2) begin
                start      = 1'b1;
                start_addr = sa ^ 26'h155_5550;
                num_words  = 16'd7;
            end
            bus.rd_ack   = 1'b0;
            bus.rd_valid = 1'b0;
            if (bus.rd_req) req_hi++;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = exp_word(word_addr(sa, pend_k)) ^ (mask[pend_k] ? flip : '0);
                end
            end else if (bus.rd_req) begin
                check({tag, " rd_addr"}, 128'(bus.rd_addr), 128'(word_addr(sa, req_idx)));
                if (req_cycles == ack_dly) begin
                    bus.rd_ack = 1'b1;
                    if (lat == 0) begin
                        bus.rd_valid = 1'b1;
                        bus.rd_data  = exp_word(word_addr(sa, req_idx)) ^ (mask[req_idx] ? flip : '0);
                    end else begin
                        cd     = lat;
                        pend_k = req_idx;
                    end
                    req_idx++;
                    req_cycles = 0;
                end else begin
                    req_cycles++;
                end
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                finished = 1;
            end
        end
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        start        = 1'b0;
        if (!finished) check({tag, " done_seen"}, 0, 1);

        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end

        to_in_req = exp_to && (ack_dly >= T);
        if (to_in_req)   exp_cyc = T + 1;
        else if (exp_to) exp_cyc = ack_dly + 1 + T + 1;
        else             exp_cyc = n * (ack_dly + lat + 2) + 1;
        if (to_in_req)   exp_hi = T;
        else if (exp_to) exp_hi = ack_dly + 1;
        else             exp_hi = n * (ack_dly + 1);
        exp_data = (exp_err > 0) ? (exp_word(exp_first) ^ flip) : '0;

        check({tag, " done_cycle"}, 128'(done_cyc), 128'(exp_cyc));
        check({tag, " done_pulses"}, 128'(dones), 128'd1);
        check({tag, " rd_req_cycles"}, 128'(req_hi), 128'(exp_hi));
        check({tag, " busy_after"}, 128'(busy), 128'd0);
        check({tag, " error_count"}, 128'(error_count), 128'(exp_err));
        check({tag, " pass"}, 128'(pass), 128'(exp_pass));
        check({tag, " timeout"}, 128'(timeout), 128'(exp_to));
        check({tag, " first_err_addr"}, 128'(first_err_addr), (exp_err > 0) ? 128'(exp_first) : 128'd0);
        check({tag, " first_err_data"}, first_err_data, exp_data);
    endtask

    vec_t vecs[7];

    initial begin
        logic [25:0]  sa, first;
        logic [7:0]   mask;
        logic [127:0] flip;
        int n, ad, lt, err, dones;

        vecs[0] = '{26'h000_0000, 4, 0, 2,   8'h00, 1'b0, 0, 1'b1, 1'b0, 26'h0};
        vecs[1] = '{26'h000_0000, 4, 0, 2,   8'h04, 1'b0, 1, 1'b0, 1'b0, 26'h20};
        vecs[2] = '{26'h000_0000, 0, 0, 0,   8'h00, 1'b0, 0, 1'b1, 1'b0, 26'h0};
        vecs[3] = '{26'h000_0100, 1, 100, 0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 26'h0};
        vecs[4] = '{26'h3FF_FFF0, 2, 0, 0,   8'h00, 1'b0, 0, 1'b1, 1'b0, 26'h0};
        vecs[5] = '{26'h000_0200, 3, 1, 1,   8'h03, 1'b1, 2, 1'b0, 1'b0, 26'h200};
        vecs[6] = '{26'h000_0400, 2, 0, 40,  8'h00, 1'b0, 0, 1'b0, 1'b1, 26'h0};

        reset        = 1'b1;
        start        = 1'b0;
        start_addr   = '0;
        num_words    = '0;
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", 128'(busy), 0);
        check("reset done", 128'(done), 0);
        check("reset pass", 128'(pass), 0);
        check("reset timeout", 128'(timeout), 0);
        check("reset error_count", 128'(error_count), 0);
        check("reset rd_req", 128'(bus.rd_req), 0);
        check("reset rd_addr", 128'(bus.rd_addr), 0);
        check("reset first_err", 128'(first_err_addr) | first_err_data, 0);

        for (int v = 0; v < 7; v++) begin
            run_vec($sformatf("vec%0d", v), vecs[v].sa, vecs[v].n, vecs[v].ack_dly, vecs[v].lat,
                    vecs[v].mask, 128'h1, vecs[v].restart, vecs[v].exp_err, vecs[v].exp_pass,
                    vecs[v].exp_to, vecs[v].exp_first);
        end

        for (int r = 0; r < 16; r++) begin
            n    = $urandom_range(1, 8);
            ad   = $urandom_range(0, 3);
            lt   = $urandom_range(0, 3);
            mask = 8'($urandom);
            flip = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            sa   = 26'($urandom) & 26'h3FF_FFF0;
            if ($urandom_range(0, 2) == 0) sa = sa | 26'h3FF_FF80;
            err   = 0;
            first = '0;
            for (int k = 0; k < n; k++) begin
                if (mask[k]) begin
                    if (err == 0) first = word_addr(sa, k);
                    err++;
                end
            end
            run_vec($sformatf("rnd%0d", r), sa, n, ad, lt, mask, flip, 1'b0, err, err == 0, 1'b0, first);
        end

        // rd_valid while idle must not disturb a finished, passing run.
        run_vec("idle_pre", 26'h000_1000, 1, 0, 0, 8'h00, 128'h1, 1'b0, 0, 1'b1, 1'b0, 26'h0);
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_data  = '1;
        @(negedge clk);
        bus.rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_valid error_count", 128'(error_count), 0);
        check("idle_valid pass", 128'(pass), 1);
        check("idle_valid busy", 128'(busy), 0);

        // Reset while waiting for data, then a late rd_valid.
        dones = 0;
        @(negedge clk);
        start      = 1'b1;
        start_addr = 26'h000_0040;
        num_words  = 16'd4;
        @(negedge clk);
        start = 1'b0;
        check("rst_seq rd_req", 128'(bus.rd_req), 1);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        check("rst_seq in_wait busy", 128'(busy), 1);
        check("rst_seq in_wait rd_req", 128'(bus.rd_req), 0);
        reset = 1'b1;
        @(negedge clk);
        if (done) dones++;
        reset = 1'b0;
        @(negedge clk);
        if (done) dones++;
        bus.rd_valid = 1'b1;
        bus.rd_data  = '1;
        @(negedge clk);
        if (done) dones++;
        bus.rd_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_seq done_pulses", 128'(dones), 0);
        check("rst_seq busy", 128'(busy), 0);
        check("rst_seq rd_req", 128'(bus.rd_req), 0);
        check("rst_seq rd_addr", 128'(bus.rd_addr), 0);
        check("rst_seq pass", 128'(pass), 0);
        check("rst_seq timeout", 128'(timeout), 0);
        check("rst_seq error_count", 128'(error_count), 0);
        check("rst_seq first_err", 128'(first_err_addr) | first_err_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
